// File: rtl/ss_sched_pkg.sv
// Shared types for the PE sum-stage scheduler: control word, state enum.
// Imported by ss_beat_cnt and ss_sched.
package ss_sched_pkg;

  localparam int PE_NBITW = 3;

  typedef struct packed {
    logic                init;
    logic                neg;
    logic [PE_NBITW-1:0] sht;
    logic                last;
  } ss_ctl_t;

  typedef struct packed {
    logic                vld;
    logic [PE_NBITW-1:0] pln;
  } pp_ctl_t;

  typedef enum logic [1:0] {
    SS_IDLE,
    SS_RUN,
    SS_DRAIN
  } ss_sched_state_e;

endpackage

// File: rtl/ss_beat_cnt.sv
// Nested bit/group/tile beat counter with load, enable and wrap flags.
// Ports: i_clk, i_rst(n), i_ld, i_en, limits in, counts and wraps out.
module ss_beat_cnt
  import ss_sched_pkg::*;
#(
  parameter int NBITW  = PE_NBITW,
  parameter int NGRPW  = 8,
  parameter int NTILEW = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ld,
  input  logic              i_en,
  input  logic [NBITW-1:0]  i_nbit,
  input  logic [NGRPW-1:0]  i_ngrp,
  input  logic [NTILEW-1:0] i_ntile,
  output logic [NBITW-1:0]  o_bit,
  output logic [NGRPW-1:0]  o_grp,
  output logic [NTILEW-1:0] o_tile,
  output logic              o_bit_wrap,
  output logic              o_grp_wrap,
  output logic              o_tile_wrap
);

  logic [NBITW-1:0]  nbit_q, nbit_d;
  logic [NGRPW-1:0]  ngrp_q, ngrp_d;
  logic [NTILEW-1:0] ntile_q, ntile_d;
  logic [NBITW-1:0]  bit_q, bit_d;
  logic [NGRPW-1:0]  grp_q, grp_d;
  logic [NTILEW-1:0] tile_q, tile_d;

  assign o_bit_wrap  = (bit_q == nbit_q);
  assign o_grp_wrap  = o_bit_wrap && (grp_q == ngrp_q);
  assign o_tile_wrap = o_grp_wrap && (tile_q == ntile_q);

  assign o_bit  = bit_q;
  assign o_grp  = grp_q;
  assign o_tile = tile_q;

  always_comb begin
    nbit_d  = nbit_q;
    ngrp_d  = ngrp_q;
    ntile_d = ntile_q;
    bit_d   = bit_q;
    grp_d   = grp_q;
    tile_d  = tile_q;
    if (i_ld) begin
      nbit_d  = i_nbit;
      ngrp_d  = i_ngrp;
      ntile_d = i_ntile;
      bit_d   = '0;
      grp_d   = '0;
      tile_d  = '0;
    end else if (i_en) begin
      // bit innermost, then group, then tile
      if (o_bit_wrap) begin
        bit_d = '0;
        if (o_grp_wrap) begin
          grp_d  = '0;
          tile_d = o_tile_wrap ? '0 : tile_q + 1'b1;
        end else begin
          grp_d = grp_q + 1'b1;
        end
      end else begin
        bit_d = bit_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      nbit_q  <= '0;
      ngrp_q  <= '0;
      ntile_q <= '0;
      bit_q   <= '0;
      grp_q   <= '0;
      tile_q  <= '0;
    end else begin
      nbit_q  <= nbit_d;
      ngrp_q  <= ngrp_d;
      ntile_q <= ntile_d;
      bit_q   <= bit_d;
      grp_q   <= grp_d;
      tile_q  <= tile_d;
    end
  end

endmodule

// File: rtl/ss_sched.sv
// PE sum-stage sequencer: job accept, SSctl generation, MS gating, done.
// Macro SS_SCHED_MSB_NEG_EN: negate the MSB bit-plane (signed weights).
module ss_sched
  import ss_sched_pkg::*;
#(
  parameter int NBITW  = PE_NBITW,
  parameter int NGRPW  = 8,
  parameter int NTILEW = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              cfg_rdy,
  output logic              cfg_ack,
  input  logic [NBITW-1:0]  i_cfg_nbit,
  input  logic [NGRPW-1:0]  i_cfg_ngrp,
  input  logic [NTILEW-1:0] i_cfg_ntile,
  input  logic              i_ms_rdy,
  output logic              o_ms_rdy,
  input  logic              i_ms_ack,
  input  logic              i_ss_rdy,
  input  logic              i_ss_ack,
  output logic [NBITW+2:0]  o_ctl,
  output logic              o_busy,
  output logic              o_done
);

  ss_sched_state_e state_q, state_d;
  logic pend_last_q, pend_last_d;

  logic run, beat, ss_hs, cfg_hs;
  logic init, neg, last, fin;
  logic bit_wrap, tile_wrap;
  logic [NBITW-1:0]  bit_cnt;
  logic [NGRPW-1:0]  grp_cnt;
  logic [NTILEW-1:0] tile_cnt;

  assign run      = (state_q == SS_RUN);
  assign cfg_ack  = (state_q == SS_IDLE);
  assign cfg_hs   = cfg_rdy && cfg_ack;
  assign o_ms_rdy = i_ms_rdy && run;
  assign beat     = o_ms_rdy && i_ms_ack;
  assign ss_hs    = i_ss_rdy && i_ss_ack;
  assign o_busy   = (state_q != SS_IDLE);
  assign o_done   = (state_q == SS_DRAIN) && !pend_last_q;

  ss_beat_cnt #(
    .NBITW (NBITW),
    .NGRPW (NGRPW),
    .NTILEW(NTILEW)
  ) u_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_ld       (cfg_hs),
    .i_en       (beat),
    .i_nbit     (i_cfg_nbit),
    .i_ngrp     (i_cfg_ngrp),
    .i_ntile    (i_cfg_ntile),
    .o_bit      (bit_cnt),
    .o_grp      (grp_cnt),
    .o_tile     (tile_cnt),
    .o_bit_wrap (bit_wrap),
    .o_grp_wrap (last),
    .o_tile_wrap(tile_wrap)
  );

  assign init = (bit_cnt == '0) && (grp_cnt == '0);
  assign fin  = tile_wrap;

`ifdef SS_SCHED_MSB_NEG_EN
  assign neg = bit_wrap;
`else
  assign neg = 1'b0;
`endif

  // ctl is only meaningful while beats can flow
  assign o_ctl = run ? {init, neg, bit_cnt, last} : '0;

  always_comb begin
    state_d     = state_q;
    pend_last_d = pend_last_q;
    // a new last beat wins over the clear of the previous one
    if (beat && last) begin
      pend_last_d = 1'b1;
    end else if (ss_hs) begin
      pend_last_d = 1'b0;
    end
    unique case (state_q)
      SS_IDLE: begin
        if (cfg_rdy) state_d = SS_RUN;
      end
      SS_RUN: begin
        if (beat && fin) state_d = SS_DRAIN;
      end
      SS_DRAIN: begin
        if (!pend_last_q) state_d = SS_IDLE;
      end
      default: state_d = SS_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= SS_IDLE;
      pend_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_last_q <= pend_last_d;
    end
  end

  logic unused_tile;
  assign unused_tile = ^tile_cnt;

endmodule

// File: tb/tb_ss_sched.sv
// Directed self-checking bench for ss_sched.
// Optional build macro: SS_SCHED_MSB_NEG_EN.
module tb_ss_sched;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        cfg_rdy = 1'b0;
  logic        cfg_ack;
  logic [2:0]  i_cfg_nbit = '0;
  logic [7:0]  i_cfg_ngrp = '0;
  logic [15:0] i_cfg_ntile = '0;
  logic        i_ms_rdy = 1'b0;
  logic        o_ms_rdy;
  logic        i_ms_ack = 1'b0;
  logic        i_ss_rdy = 1'b0;
  logic        i_ss_ack = 1'b0;
  logic [5:0]  o_ctl;
  logic        o_busy;
  logic        o_done;

  int n_cmp = 0;
  int n_bad = 0;

  ss_sched dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .cfg_rdy    (cfg_rdy),
    .cfg_ack    (cfg_ack),
    .i_cfg_nbit (i_cfg_nbit),
    .i_cfg_ngrp (i_cfg_ngrp),
    .i_cfg_ntile(i_cfg_ntile),
    .i_ms_rdy   (i_ms_rdy),
    .o_ms_rdy   (o_ms_rdy),
    .i_ms_ack   (i_ms_ack),
    .i_ss_rdy   (i_ss_rdy),
    .i_ss_ack   (i_ss_ack),
    .o_ctl      (o_ctl),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [5:0] mk(logic init, logic neg,
                                    logic [2:0] sht, logic last);
    return {init, neg, sht, last};
  endfunction

  function automatic logic negf(logic [2:0] sht, logic [2:0] nb);
`ifdef SS_SCHED_MSB_NEG_EN
    return sht == nb;
`else
    return 1'b0;
`endif
  endfunction

  task automatic test_reset();
    i_ms_rdy = 1'b1;
    i_ms_ack = 1'b1;
    i_rst = 1'b0;
    cyc();
    cyc();
    n_cmp++;
    if (cfg_ack !== 1'b1) begin
      n_bad++; $display("FAIL rst_cfg_ack: got %b want 1", cfg_ack);
    end
    n_cmp++;
    if (o_ms_rdy !== 1'b0) begin
      n_bad++; $display("FAIL rst_ms_rdy: got %b want 0", o_ms_rdy);
    end
    n_cmp++;
    if ({o_busy, o_done} !== 2'b00) begin
      n_bad++; $display("FAIL rst_busy_done: got %b want 00", {o_busy, o_done});
    end
    n_cmp++;
    if (o_ctl !== 6'h00) begin
      n_bad++; $display("FAIL rst_ctl: got %h want 00", o_ctl);
    end
    i_rst = 1'b1;
    i_ss_rdy = 1'b1;
    i_ss_ack = 1'b1;
    cyc();
    n_cmp++;
    if (o_ms_rdy !== 1'b0) begin
      n_bad++; $display("FAIL idle_ms_block: got %b want 0", o_ms_rdy);
    end
  endtask

  task automatic test_basic();
    logic [2:0] s;
    cfg_rdy = 1'b1;
    i_cfg_nbit = 3'd3;
    i_cfg_ngrp = 8'd1;
    i_cfg_ntile = 16'd0;
    #1;
    n_cmp++;
    if (cfg_ack !== 1'b1) begin
      n_bad++; $display("FAIL basic_ack: got %b want 1", cfg_ack);
    end
    cyc();
    cfg_rdy = 1'b0;
    #1;
    for (int b = 0; b < 8; b++) begin
      s = 3'(b % 4);
      n_cmp++;
      if (o_ms_rdy !== 1'b1) begin
        n_bad++; $display("FAIL basic_ms_rdy[%0d]: got %b want 1", b, o_ms_rdy);
      end
      n_cmp++;
      if (o_ctl !== mk(b == 0, negf(s, 3'd3), s, b == 7)) begin
        n_bad++;
        $display("FAIL basic_ctl[%0d]: got %h want %h", b, o_ctl,
                 mk(b == 0, negf(s, 3'd3), s, b == 7));
      end
      cyc();
    end
    n_cmp++;
    if ({o_busy, o_done, o_ms_rdy} !== 3'b100) begin
      n_bad++;
      $display("FAIL basic_drain: got %b want 100", {o_busy, o_done, o_ms_rdy});
    end
    cyc();
    n_cmp++;
    if (o_done !== 1'b1) begin
      n_bad++; $display("FAIL basic_done: got %b want 1", o_done);
    end
    cyc();
    n_cmp++;
    if ({o_busy, o_done, cfg_ack} !== 3'b001) begin
      n_bad++;
      $display("FAIL basic_idle: got %b want 001", {o_busy, o_done, cfg_ack});
    end
  endtask

  task automatic test_multi_tile();
    cfg_rdy = 1'b1;
    i_cfg_nbit = 3'd0;
    i_cfg_ngrp = 8'd0;
    i_cfg_ntile = 16'd3;
    cyc();
    cfg_rdy = 1'b0;
    #1;
    for (int b = 0; b < 4; b++) begin
      n_cmp++;
      if (o_ctl !== mk(1'b1, negf(3'd0, 3'd0), 3'd0, 1'b1)) begin
        n_bad++;
        $display("FAIL mt_ctl[%0d]: got %h want %h", b, o_ctl,
                 mk(1'b1, negf(3'd0, 3'd0), 3'd0, 1'b1));
      end
      n_cmp++;
      if (o_done !== 1'b0) begin
        n_bad++; $display("FAIL mt_early_done[%0d]: got %b want 0", b, o_done);
      end
      cyc();
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (o_done !== (k == 1)) begin
        n_bad++; $display("FAIL mt_done[%0d]: got %b want %b", k, o_done, k == 1);
      end
      cyc();
    end
  endtask

  task automatic test_stall();
    cfg_rdy = 1'b1;
    i_cfg_nbit = 3'd3;
    i_cfg_ngrp = 8'd1;
    i_cfg_ntile = 16'd0;
    cyc();
    cfg_rdy = 1'b0;
    cyc();
    cyc();
    i_ms_ack = 1'b0;
    i_ss_ack = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (o_ctl !== mk(1'b0, negf(3'd2, 3'd3), 3'd2, 1'b0)) begin
        n_bad++;
        $display("FAIL stall_ctl[%0d]: got %h want %h", i, o_ctl,
                 mk(1'b0, negf(3'd2, 3'd3), 3'd2, 1'b0));
      end
      cyc();
    end
    i_ms_ack = 1'b1;
    i_ss_ack = 1'b1;
    #1;
    for (int b = 2; b < 8; b++) begin
      n_cmp++;
      if (o_ctl !== mk(1'b0, negf(3'(b % 4), 3'd3), 3'(b % 4), b == 7)) begin
        n_bad++;
        $display("FAIL stall_resume[%0d]: got %h want %h", b, o_ctl,
                 mk(1'b0, negf(3'(b % 4), 3'd3), 3'(b % 4), b == 7));
      end
      cyc();
    end
    cyc();
    n_cmp++;
    if (o_done !== 1'b1) begin
      n_bad++; $display("FAIL stall_done: got %b want 1", o_done);
    end
    cyc();
  endtask

  task automatic test_set_clear();
    cfg_rdy = 1'b1;
    i_cfg_nbit = 3'd0;
    i_cfg_ngrp = 8'd0;
    i_cfg_ntile = 16'd1;
    cyc();
    cfg_rdy = 1'b0;
    i_ss_ack = 1'b0;
    #1;
    cyc();
    i_ss_ack = 1'b1;
    #1;
    n_cmp++;
    if (o_ms_rdy !== 1'b1) begin
      n_bad++; $display("FAIL sc_beat1: got %b want 1", o_ms_rdy);
    end
    cyc();
    i_ss_ack = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({o_busy, o_done} !== 2'b10) begin
        n_bad++;
        $display("FAIL sc_hold[%0d]: got %b want 10", i, {o_busy, o_done});
      end
      cyc();
    end
    i_ss_ack = 1'b1;
    #1;
    n_cmp++;
    if (o_done !== 1'b0) begin
      n_bad++; $display("FAIL sc_ack_cycle: got %b want 0", o_done);
    end
    cyc();
    n_cmp++;
    if (o_done !== 1'b1) begin
      n_bad++; $display("FAIL sc_done: got %b want 1", o_done);
    end
    cyc();
    n_cmp++;
    if (o_busy !== 1'b0) begin
      n_bad++; $display("FAIL sc_idle: got %b want 0", o_busy);
    end
  endtask

  task automatic test_back_to_back();
    cfg_rdy = 1'b1;
    i_cfg_nbit = 3'd1;
    i_cfg_ngrp = 8'd0;
    i_cfg_ntile = 16'd0;
    #1;
    cyc();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({cfg_ack, o_busy, o_done} !== {2'b01, i == 3}) begin
        n_bad++;
        $display("FAIL b2b_busy[%0d]: got %b want %b", i,
                 {cfg_ack, o_busy, o_done}, {2'b01, i == 3});
      end
      cyc();
    end
    n_cmp++;
    if ({cfg_ack, o_busy} !== 2'b10) begin
      n_bad++; $display("FAIL b2b_idle: got %b want 10", {cfg_ack, o_busy});
    end
    cyc();
    n_cmp++;
    if ({o_busy, o_ctl} !== {1'b1, mk(1'b1, 1'b0, 3'd0, 1'b0)}) begin
      n_bad++;
      $display("FAIL b2b_second: got %h want %h", {o_busy, o_ctl},
               {1'b1, mk(1'b1, 1'b0, 3'd0, 1'b0)});
    end
    cfg_rdy = 1'b0;
    #2;
    i_rst = 1'b0;
    #1;
    n_cmp++;
    if ({cfg_ack, o_ms_rdy, o_busy, o_done, o_ctl} !== {4'b1000, 6'h00}) begin
      n_bad++;
      $display("FAIL b2b_reset: got %h want %h",
               {cfg_ack, o_ms_rdy, o_busy, o_done, o_ctl}, {4'b1000, 6'h00});
    end
    cyc();
    i_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_cmp++;
      if ({o_busy, o_done} !== 2'b00) begin
        n_bad++;
        $display("FAIL b2b_post_rst[%0d]: got %b want 00", i, {o_busy, o_done});
      end
    end
  endtask

  task automatic test_neg();
    cfg_rdy = 1'b1;
    i_cfg_nbit = 3'd7;
    i_cfg_ngrp = 8'd0;
    i_cfg_ntile = 16'd0;
    cyc();
    cfg_rdy = 1'b0;
    #1;
    for (int b = 0; b < 8; b++) begin
      n_cmp++;
      if (o_ctl !== mk(b == 0, negf(3'(b), 3'd7), 3'(b), b == 7)) begin
        n_bad++;
        $display("FAIL neg_ctl[%0d]: got %h want %h", b, o_ctl,
                 mk(b == 0, negf(3'(b), 3'd7), 3'(b), b == 7));
      end
      cyc();
    end
    cyc();
    n_cmp++;
    if (o_done !== 1'b1) begin
      n_bad++; $display("FAIL neg_done: got %b want 1", o_done);
    end
    cyc();
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_multi_tile();
    test_stall();
    test_set_clear();
    test_neg();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
